// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, drives the imem read
// address and captures the returned word into the IF/ID pipeline register.
// Handles stall, redirect with squash, and a BOOT/RUN/HALTED control FSM.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_next,
    output logic        halted
);

    // PC width; the PC wraps naturally modulo IMEM_DEPTH at this width.
    localparam int unsigned PW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [PW-1:0]   pc_inc;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PW-1:0]   id_pc_q, id_pc_d;
    logic [PW-1:0]   id_pc_next_q, id_pc_next_d;

    assign pc_inc = pc_q + PW'(1);

    // State and pipeline register; async reset returns everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC[PW-1:0];
            valid_q      <= 1'b0;
            instr_q      <= NOP_WORD;
            id_pc_q      <= '0;
            id_pc_next_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
        end
    end

    // Next-state: redirect beats stall; stall holds PC and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        unique case (state_q)
            StBoot: begin
                // No capture and redirect ignored during the boot cycle.
                valid_d = 1'b0;
                state_d = halt ? StHalted : StRun;
            end
            StRun: begin
                if (redirect) begin
                    pc_d    = redirect_pc[PW-1:0];
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (!stall) begin
                    instr_d      = imem_data;
                    id_pc_d      = pc_q;
                    id_pc_next_d = pc_inc;
                    valid_d      = 1'b1;
                    pc_d         = pc_inc;
                end
                if (halt && !stall) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (redirect) begin
                    pc_d    = redirect_pc[PW-1:0];
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
                // Leaving HALTED does not fetch; the fetch resumes next edge.
                if (!halt) begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // Outputs are zero-extended views of the registered state.
    always_comb begin
        imem_addr  = 32'(pc_q);
        id_valid   = valid_q;
        id_instr   = instr_q;
        id_pc      = 32'(id_pc_q);
        id_pc_next = 32'(id_pc_next_q);
        halted     = (state_q == StHalted);
    end

endmodule
